// File: rtl/melody_sequencer.sv
// Score-driven melody player: steps through a small writable score RAM and
// drives the beeper tone generator with one note code per entry plus silent gaps.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 3000000,
    parameter int GAP_CYCLES  = 120000,
    parameter int DEPTH       = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    output logic [4:0]    tone,
    output logic          tone_en,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] note_idx
);

    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] IDX_ZERO  = {AW{1'b0}};
    localparam logic          HAS_GAP   = (GAP_CYCLES > 0);
    localparam logic [4:0]    CODE_END  = 5'd31;
    localparam logic [4:0]    CODE_NOTE_MAX = 5'd21;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    state_t        state_r;
    logic [7:0]    mem_r [DEPTH];
    logic [7:0]    rd_data_r;
    logic [AW-1:0] idx_r;
    logic [BW-1:0] cyc_cnt_r;
    logic [2:0]    beats_left_r;
    logic [GW-1:0] gap_cnt_r;

    logic [4:0]    code_s;
    logic [2:0]    dur_s;
    logic          is_end_s;
    logic          is_note_s;
    logic          play_last_s;
    logic          adv_s;
    logic          finish_s;

    // Score RAM: synchronous write, registered read of the current index.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST_IDX)) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data_r <= mem_r[idx_r];
    end

    // Entry decode and end-of-entry conditions.
    always_comb begin
        code_s      = rd_data_r[4:0];
        dur_s       = rd_data_r[7:5];
        is_end_s    = (code_s == CODE_END);
        is_note_s   = (code_s != 5'd0) && (code_s <= CODE_NOTE_MAX);
        play_last_s = (cyc_cnt_r == BEAT_LAST) && (beats_left_r == 3'd0);
        if (state_r == ST_PLAY) begin
            adv_s = play_last_s && !HAS_GAP;
        end else if (state_r == ST_GAP) begin
            adv_s = (gap_cnt_r == GAP_LAST);
        end else begin
            adv_s = 1'b0;
        end
        // The last entry behaves like an END marker when advancing.
        finish_s = (idx_r == LAST_IDX) && !loop_en;
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            cyc_cnt_r    <= {BW{1'b0}};
            beats_left_r <= 3'd0;
            gap_cnt_r    <= {GW{1'b0}};
            tone         <= 5'd0;
            tone_en      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            note_idx     <= IDX_ZERO;
        end else if (stop && (state_r != ST_IDLE)) begin
            state_r <= ST_IDLE;
            tone    <= 5'd0;
            tone_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !stop) begin
                        idx_r   <= IDX_ZERO;
                        busy    <= 1'b1;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (is_end_s) begin
                        // END at entry 0 would loop forever with no playback.
                        if (loop_en && (idx_r != IDX_ZERO)) begin
                            idx_r   <= IDX_ZERO;
                            state_r <= ST_FETCH;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        tone         <= is_note_s ? code_s : 5'd0;
                        tone_en      <= is_note_s;
                        note_idx     <= idx_r;
                        cyc_cnt_r    <= {BW{1'b0}};
                        beats_left_r <= dur_s;
                        state_r      <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (cyc_cnt_r == BEAT_LAST) begin
                        cyc_cnt_r    <= {BW{1'b0}};
                        beats_left_r <= beats_left_r - 3'd1;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + BW'(1);
                    end
                    if (play_last_s) begin
                        tone      <= 5'd0;
                        tone_en   <= 1'b0;
                        gap_cnt_r <= {GW{1'b0}};
                        state_r   <= ST_GAP;
                    end else begin
                        state_r <= ST_PLAY;
                    end
                end
                ST_GAP: begin
                    gap_cnt_r <= gap_cnt_r + GW'(1);
                    state_r   <= ST_GAP;
                end
                default: begin
                    tone    <= 5'd0;
                    tone_en <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
            // Advance overrides the PLAY/GAP next state chosen above.
            if (adv_s) begin
                if (finish_s) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= ST_IDLE;
                end else begin
                    idx_r   <= (idx_r == LAST_IDX) ? IDX_ZERO : idx_r + AW'(1);
                    state_r <= ST_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized bench for melody_sequencer: expands each score into its expected
// per-cycle output waveform and compares the DUT against it cycle by cycle.
module tb_melody_sequencer;

    localparam int BEAT  = 10;
    localparam int GAP   = 2;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [4:0]    tone;
    logic          tone_en;
    logic          busy;
    logic          done;
    logic [AW-1:0] note_idx;
    logic [10:0]   dut_v;

    int checks = 0;
    int errors = 0;
    logic [7:0]  score_m [DEPTH];
    logic [10:0] exp_q [$];
    logic [2:0]  cur_ni;

    melody_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .tone    (tone),
        .tone_en (tone_en),
        .busy    (busy),
        .done    (done),
        .note_idx(note_idx)
    );

    assign dut_v = {tone_en, tone, busy, done, note_idx};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] pk(input logic en, input logic [4:0] t, input logic b,
                                       input logic d, input logic [2:0] ni);
        return {en, t, b, d, ni};
    endfunction

    // Expected outputs after each clock edge, starting with the edge that takes start.
    // loop_en reads as 0 for any decision whose result lands after index loff.
    task automatic build_exp(input bit lp, input int loff, input logic [2:0] ni0);
        int idx = 0;
        bit fin = 0;
        bit lpe;
        logic [2:0] ni = ni0;
        logic [4:0] code;
        int len;
        bit note;
        exp_q.delete();
        while (!fin && exp_q.size() < 5000) begin
            repeat (2) exp_q.push_back(pk(1'b0, 5'd0, 1'b1, 1'b0, ni));
            code = score_m[idx][4:0];
            len  = (int'(score_m[idx][7:5]) + 1) * BEAT;
            lpe  = lp && !(loff >= 0 && exp_q.size() > loff);
            if (code == 5'd31) begin
                if (lpe && idx != 0) idx = 0;
                else fin = 1;
            end else begin
                note = (code >= 5'd1) && (code <= 5'd21);
                ni   = idx[2:0];
                repeat (len) exp_q.push_back(pk(note, note ? code : 5'd0, 1'b1, 1'b0, ni));
                repeat (GAP) exp_q.push_back(pk(1'b0, 5'd0, 1'b1, 1'b0, ni));
                lpe = lp && !(loff >= 0 && exp_q.size() > loff);
                if (idx == DEPTH - 1) begin
                    if (lpe) idx = 0;
                    else fin = 1;
                end else begin
                    idx++;
                end
            end
        end
        exp_q.push_back(pk(1'b0, 5'd0, 1'b0, 1'b1, ni));
        repeat (3) exp_q.push_back(pk(1'b0, 5'd0, 1'b0, 1'b0, ni));
    endtask

    task automatic write_score();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = i[2:0];
            wr_data = score_m[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run(input string tag, input bit lp, input int loff, input int stop_at,
                       input int bstart);
        logic [10:0] ev;
        logic [10:0] stop_v = 11'd0;
        bit stopped = 0;
        int after = 0;
        write_score();
        loop_en = lp;
        build_exp(lp, loff, cur_ni);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            ev = stopped ? stop_v : exp_q[k];
            check_eq($sformatf("%s@%0d", tag, k), {21'd0, dut_v}, {21'd0, ev});
            cur_ni = ev[2:0];
            if (stopped) begin
                stop = 1'b0;
                after++;
                if (after == 3) break;
            end
            if (k == stop_at) begin
                stop    = 1'b1;
                stopped = 1;
                stop_v  = pk(1'b0, 5'd0, 1'b0, 1'b0, ev[2:0]);
            end
            if (k == loff) loop_en = 1'b0;
            if (k == bstart) start = 1'b1;
            else if (k == bstart + 1) start = 1'b0;
        end
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic set_t1();
        score_m[0] = 8'h28;
        score_m[1] = 8'h0C;
        for (int i = 2; i < DEPTH; i++) score_m[i] = 8'h1F;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'd0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        cur_ni  = 3'd0;
        #12;
        check_eq("reset", {21'd0, dut_v}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        set_t1();
        run("basic", 0, -1, -1, -1);

        score_m[0] = 8'h40;
        score_m[1] = 8'h1F;
        run("rest", 0, -1, -1, -1);

        set_t1();
        run("loop", 1, 50, -1, -1);
        run("stop", 0, -1, 6, -1);
        run("restart", 0, -1, -1, -1);
        run("start_busy", 0, -1, -1, 10);

        for (int i = 0; i < DEPTH; i++) score_m[i] = 8'h01;
        run("noend", 0, -1, -1, -1);
        run("noend_loop", 1, 150, -1, -1);

        for (int i = 0; i < DEPTH; i++) score_m[i] = 8'h1F;
        run("end0", 1, -1, -1, -1);

        // start and stop together must leave the sequencer idle
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        stop = 1'b0;
        check_eq("start_stop_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 check_eq("start_stop_idle", {21'd0, dut_v}, {21'd0, pk(1'b0, 5'd0, 1'b0, 1'b0, cur_ni)});

        // asynchronous reset in the middle of a note
        set_t1();
        write_score();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 check_eq("pre_rst_play", {21'd0, dut_v}, {21'd0, pk(1'b1, 5'd8, 1'b1, 1'b0, 3'd0)});
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst", {21'd0, dut_v}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        cur_ni = 3'd0;

        for (int r = 0; r < 24; r++) begin
            bit lp;
            int loff;
            int sat;
            for (int i = 0; i < DEPTH; i++) begin
                int sel = $urandom_range(0, 9);
                logic [4:0] c;
                if (sel == 0) c = 5'd31;
                else if (sel <= 2) c = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(22, 30));
                else c = 5'($urandom_range(1, 21));
                score_m[i] = {3'($urandom_range(0, 2)), c};
            end
            lp   = ($urandom_range(0, 1) == 1);
            loff = lp ? $urandom_range(0, 400) : -1;
            sat  = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 60) : -1;
            run($sformatf("rand%0d", r), lp, loff, sat, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
